fetch_ctrl: RTL and testbench

// Sequences the fetch stage: owns the PC, issues fetch requests (en/addr),

---
 rtl/fetch_ctrl.sv | 67 ++++++
 tb/tb_fetch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues 1-cycle-latency fetch requests and queues responses for decode.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_en,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ready,
  input  logic [15:0] fetch_instr,
  input  logic [15:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        dec_valid,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc,
  input  logic        dec_ready
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] QD = (CW+1)'(QUEUE_DEPTH);
  logic [15:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic inflight_q, push, pop;
  logic [CW:0] credit;
  logic [15:0] instr_mem [QUEUE_DEPTH];
  logic [15:0] pc_mem [QUEUE_DEPTH];
  // credit counts queued entries plus the outstanding response, less the slot freed this cycle
  always_comb begin
    dec_valid = (count_q != '0) & ~redirect_valid;
    pop = dec_valid & dec_ready;
    push = fetch_ready & ~redirect_valid;
    credit = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    fetch_en = rst_n & ~halt & ~redirect_valid & (credit < QD);
    fetch_addr = pc_q;
    dec_instr = (count_q != '0) ? instr_mem[rd_q] : 16'h0000;
    dec_pc = (count_q != '0) ? pc_mem[rd_q] : 16'h0000;
    pc_d = redirect_valid ? (redirect_pc & 16'hFFFE) : fetch_en ? pc_q + 16'd2 : pc_q;
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d = redirect_valid ? '0 : wr_q + AW'(push);
    rd_d = redirect_valid ? '0 : rd_q + AW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC & 16'hFFFE;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      inflight_q <= fetch_en;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= fetch_instr;
      pc_mem[wr_q] <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a decode-side scoreboard for fetch_ctrl.
module tb_fetch_ctrl;
  logic clk, rst_n, fetch_en, fetch_ready, redirect_valid, halt, dec_valid, dec_ready;
  logic [15:0] fetch_addr, fetch_instr, fetch_pc, redirect_pc, dec_instr, dec_pc;
  int n_tests = 0, n_fail = 0;
  logic [15:0] exp_q [$];

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return 16'h0102 + a * 16'h0112;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string name, input logic en, input logic [15:0] addr);
    @(negedge clk);
    chk({name, "_en"}, fetch_en, en);
    chk({name, "_addr"}, fetch_addr, addr);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_en"}, fetch_en, 0);
    chk({name, "_addr"}, fetch_addr, 16'h0000);
    chk({name, "_dvalid"}, dec_valid, 0);
    chk({name, "_dinstr"}, dec_instr, 16'h0000);
    chk({name, "_dpc"}, dec_pc, 16'h0000);
  endtask

  task automatic drain();
    int n = 0;
    halt = 1'b1;
    dec_ready = 1'b1;
    while ((exp_q.size() != 0 || dec_valid) && n < 30) begin
      tick();
      n++;
    end
    chk("drain_done", n < 30, 1);
    tick();
    tick();
  endtask

  // one-cycle-latency fetch stage responder
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ready <= 1'b0;
      fetch_pc <= 16'h0000;
      fetch_instr <= 16'h0000;
    end else begin
      fetch_ready <= fetch_en;
      fetch_pc <= fetch_addr;
      fetch_instr <= instr_of(fetch_addr);
    end
  end

  always @(negedge clk) begin
    if (rst_n && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dec_unexpected got pc=%h required none", dec_pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("dec_pc", dec_pc, e);
        chk("dec_instr", dec_instr, instr_of(e));
      end
    end
    if (rst_n && fetch_ready && !redirect_valid && !(dec_valid && dec_ready) && dut.count_q == 2) begin
      n_fail++;
      $display("FAIL overflow got count=%0d required <2", dut.count_q);
    end
    if (rst_n && dec_valid && dut.count_q == 0) begin
      n_fail++;
      $display("FAIL empty_valid got count=0 required nonzero");
    end
  end

  initial begin
    rst_n = 1'b0; halt = 1'b0; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    #3;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(2 * i));
      chk_fetch("t1", 1'b1, 16'(2 * i));
      tick();
    end
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_fetch("t2_stall", 1'b0, 16'h0008);
      chk("t2_head", dec_pc, 16'h0004);
      tick();
    end
    dec_ready = 1'b1;
    exp_q.push_back(16'h0008);
    chk_fetch("t2_reuse", 1'b1, 16'h0008);
    tick();
    drain();
    halt = 1'b0;
    exp_q.push_back(16'h000A);
    chk_fetch("t5_req", 1'b1, 16'h000A);
    tick();
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_fetch("t5_halt", 1'b0, 16'h000C);
      tick();
    end
    chk("t5_delivered", exp_q.size(), 0);
    halt = 1'b0;
    exp_q.push_back(16'h000C);
    chk_fetch("t5_resume", 1'b1, 16'h000C);
    tick();
    drain();
    halt = 1'b0;
    dec_ready = 1'b0;
    chk_fetch("t3_c0", 1'b1, 16'h000E);
    tick();
    chk_fetch("t3_c1", 1'b1, 16'h0010);
    tick();
    chk_fetch("t3_c2", 1'b0, 16'h0012);
    tick();
    chk_fetch("t3_full", 1'b0, 16'h0012);
    chk("t3_full_valid", dec_valid, 1);
    chk("t3_full_head", dec_pc, 16'h000E);
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0011; dec_ready = 1'b1;
    @(negedge clk);
    chk("t3_redir_valid", dec_valid, 0);
    chk("t3_redir_en", fetch_en, 0);
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(16'h0010);
    chk_fetch("t3_new", 1'b1, 16'h0010);
    chk("t3_after_valid", dec_valid, 0);
    tick();
    drain();
    halt = 1'b0;
    chk_fetch("t4_stale", 1'b1, 16'h0012);
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    chk("t4_redir_en", fetch_en, 0);
    chk("t4_redir_valid", dec_valid, 0);
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(16'hFFFE);
    chk_fetch("t4_fffe", 1'b1, 16'hFFFE);
    tick();
    exp_q.push_back(16'h0000);
    chk_fetch("t4_wrap", 1'b1, 16'h0000);
    tick();
    exp_q.push_back(16'h0002);
    chk_fetch("t4_next", 1'b1, 16'h0002);
    tick();
    drain();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    chk_fetch("th_redir", 1'b0, 16'h0004);
    tick();
    redirect_valid = 1'b0;
    chk_fetch("th_held", 1'b0, 16'h0100);
    tick();
    halt = 1'b0;
    exp_q.push_back(16'h0100);
    chk_fetch("th_resume", 1'b1, 16'h0100);
    tick();
    drain();
    halt = 1'b0;
    exp_q.push_back(16'h0102);
    chk_fetch("t6_c0", 1'b1, 16'h0102);
    tick();
    chk_fetch("t6_c1", 1'b1, 16'h0104);
    tick();
    chk_fetch("t6_c2", 1'b1, 16'h0106);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_async");
    chk("t6_delivered", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(16'h0000);
    chk_fetch("t6_restart", 1'b1, 16'h0000);
    tick();
    exp_q.push_back(16'h0002);
    chk_fetch("t6_next", 1'b1, 16'h0002);
    tick();
    drain();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
